// File: rtl/spi_slave_ctrl_if.sv
// Strobe/enable bundle between the SPI input conditioner, the slave controller and its datapath.
interface spi_slave_ctrl_if;
  logic sclk_rise;
  logic sclk_fall;
  logic cs;
  logic mosi;
  logic miso_buff;
  logic addr_we;
  logic sr_we;
  logic dm_we;
  logic addr_inc;
  logic frame_err;

  modport slave (
    input  sclk_rise, sclk_fall, cs, mosi,
    output miso_buff, addr_we, sr_we, dm_we, addr_inc, frame_err
  );

  modport master (
    output sclk_rise, sclk_fall, cs, mosi,
    input  miso_buff, addr_we, sr_we, dm_we, addr_inc, frame_err
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave transaction controller: address / R-W / data framing with abort and framing-error detection.
// Define SPI_SLAVE_BURST_EN to keep transferring words with address auto-increment until cs rises.
module spi_slave_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_ctrl_if.slave  bus
);

`ifdef SPI_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RW, S_READ, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          miso_buff_q, miso_buff_d;
  logic          addr_we_q, addr_we_d;
  logic          sr_we_q, sr_we_d;
  logic          dm_we_q, dm_we_d;
  logic          addr_inc_q, addr_inc_d;
  logic          frame_err_q, frame_err_d;

  logic rise, fall, abort, addr_last, wr_last, rd_last;

  // A coincident fall is dropped so a glitched strobe pair counts as a single rise.
  assign rise      = bus.sclk_rise;
  assign fall      = bus.sclk_fall & ~bus.sclk_rise;
  assign cnt_inc   = cnt_q + CW'(1);
  assign abort     = bus.cs && (state_q != S_IDLE) && (state_q != S_DONE);
  assign addr_last = rise && (cnt_inc == CW'(ADDR_W));
  assign wr_last   = rise && (cnt_inc == CW'(DATA_W));
  assign rd_last   = fall && (cnt_inc == CW'(DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      miso_buff_q <= 1'b0;
      addr_we_q   <= 1'b0;
      sr_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      addr_inc_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miso_buff_q <= miso_buff_d;
      addr_we_q   <= addr_we_d;
      sr_we_q     <= sr_we_d;
      dm_we_q     <= dm_we_d;
      addr_inc_q  <= addr_inc_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (!bus.cs) state_d = S_ADDR;
        S_ADDR:  if (addr_last) state_d = S_RW;
                 else if (rise) cnt_d = cnt_inc;
        S_RW:    if (rise) state_d = bus.mosi ? S_READ : S_WRITE;
        S_READ:  if (rd_last) begin
                   cnt_d = '0;
                   if (!BURST) state_d = S_DONE;
                 end else if (fall) cnt_d = cnt_inc;
        S_WRITE: if (wr_last) begin
                   cnt_d = '0;
                   if (!BURST) state_d = S_DONE;
                 end else if (rise) cnt_d = cnt_inc;
        S_DONE:  if (bus.cs) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // Output next-state; the burst reload trails addr_inc by one clk so the latch settles first.
  always_comb begin
    miso_buff_d = 1'b0;
    addr_we_d   = 1'b0;
    sr_we_d     = 1'b0;
    dm_we_d     = 1'b0;
    addr_inc_d  = 1'b0;
    if (!abort) begin
      case (state_q)
        S_IDLE:  addr_we_d = !bus.cs;
        S_ADDR:  addr_we_d = !addr_last;
        S_RW:    if (rise && bus.mosi) begin
                   sr_we_d     = 1'b1;
                   miso_buff_d = 1'b1;
                 end
        S_READ:  begin
                   miso_buff_d = BURST || !rd_last;
                   addr_inc_d  = BURST && rd_last;
                   sr_we_d     = addr_inc_q;
                 end
        S_WRITE: begin
                   dm_we_d    = wr_last;
                   addr_inc_d = BURST && dm_we_q;
                 end
        default: ;
      endcase
    end
    // A read word that completes on the same clk cs rises has been fully shifted out.
    frame_err_d = abort && ((state_q == S_ADDR) || (state_q == S_RW) ||
                            ((cnt_q != '0) && !((state_q == S_READ) && rd_last)));
  end

  assign bus.miso_buff = miso_buff_q;
  assign bus.addr_we   = addr_we_q;
  assign bus.sr_we     = sr_we_q;
  assign bus.dm_we     = dm_we_q;
  assign bus.frame_err = frame_err_q;
`ifdef SPI_SLAVE_BURST_EN
  assign bus.addr_inc  = addr_inc_q;
`else
  assign bus.addr_inc  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: default geometry plus a 4-bit address / 12-bit data instance.
module tb_spi_slave_ctrl;

`ifdef SPI_SLAVE_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_rise = 1'b0;
  logic sclk_fall = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;

  always #5 clk = ~clk;

  spi_slave_ctrl_if if0 ();
  spi_slave_ctrl_if if1 ();

  assign if0.sclk_rise = sclk_rise;
  assign if0.sclk_fall = sclk_fall;
  assign if0.cs        = cs;
  assign if0.mosi      = mosi;
  assign if1.sclk_rise = sclk_rise;
  assign if1.sclk_fall = sclk_fall;
  assign if1.cs        = cs;
  assign if1.mosi      = mosi;

  spi_slave_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  spi_slave_ctrl #(.ADDR_W(4), .DATA_W(12)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic [5:0] o0, o1;
  assign o0 = {if0.miso_buff, if0.addr_we, if0.sr_we, if0.dm_we, if0.addr_inc, if0.frame_err};
  assign o1 = {if1.miso_buff, if1.addr_we, if1.sr_we, if1.dm_we, if1.addr_inc, if1.frame_err};

  // Running pulse counts; tests compare deltas against snapshots.
  int dm0 = 0, sr0 = 0, inc0 = 0, fe0 = 0, dm1 = 0, fe1 = 0;
  always @(negedge clk) begin
    if (if0.dm_we)     dm0++;
    if (if0.sr_we)     sr0++;
    if (if0.addr_inc)  inc0++;
    if (if0.frame_err) fe0++;
    if (if1.dm_we)     dm1++;
    if (if1.frame_err) fe1++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    tick();
    tick();
  endtask

  task automatic strobe_r(input logic m);
    mosi = m;
    sclk_rise = 1'b1;
    tick();
    sclk_rise = 1'b0;
  endtask

  task automatic strobe_f();
    sclk_fall = 1'b1;
    tick();
    sclk_fall = 1'b0;
  endtask

  task automatic send_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      strobe_r(v[i]);
      gap();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s_dm, s_sr, s_inc, s_fe, s_dm1, s_fe1;

    repeat (2) tick();
    check("rst_outs_u0", o0, 0);
    check("rst_outs_u1", o1, 0);
    rst_n = 1'b1;
    tick();
    check("idle_cs_high", o0, 0);

    // Reset in WRITE with counter = 3
    s_fe = fe0;
    cs = 1'b0;
    tick();
    check("addr_we_on_select", if0.addr_we, 1);
    send_bits(7'h15, 7);
    strobe_r(1'b0);
    gap();
    send_bits(3'b101, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", o0, 0);
    cs = 1'b1;
    tick();
    rst_n = 1'b1;
    gap();
    check("rst_no_frame_err", fe0 - s_fe, 0);
    check("rst_idle_outs", o0, 0);

    // Write addr 0x15, data 0xA5
    s_dm = dm0; s_sr = sr0; s_fe = fe0; s_inc = inc0;
    cs = 1'b0;
    tick();
    send_bits(7'h0A, 6);
    check("addr_we_held", if0.addr_we, 1);
    strobe_r(1'b1);
    check("addr_we_fall", if0.addr_we, 0);
    gap();
    strobe_r(1'b0);
    check("rw_write_outs", o0, 0);
    gap();
    send_bits(8'h52, 7);
    strobe_r(1'b1);
    check("dm_we_pulse", if0.dm_we, 1);
    tick();
    check("dm_we_single", if0.dm_we, 0);
    gap();
    check("wr_dm_count", dm0 - s_dm, 1);
    check("wr_no_sr_we", sr0 - s_sr, 0);
`ifndef SPI_SLAVE_BURST_EN
    strobe_r(1'b1); gap();
    strobe_f();     gap();
    strobe_r(1'b0); gap();
    strobe_f();     gap();
    strobe_r(1'b1); gap();
    check("extra_no_dm", dm0 - s_dm, 1);
    check("extra_no_inc", inc0 - s_inc, 0);
    check("done_held_outs", o0, 0);
`endif
    cs = 1'b1;
    gap();
    check("wr_no_frame_err", fe0 - s_fe, 0);

    // Read addr 0x7F
    s_sr = sr0; s_dm = dm0; s_fe = fe0;
    cs = 1'b0;
    tick();
    send_bits(7'h7F, 7);
    strobe_r(1'b1);
    check("rd_sr_we_load", if0.sr_we, 1);
    check("rd_miso_on", if0.miso_buff, 1);
    tick();
    check("rd_sr_we_single", if0.sr_we, 0);
    tick();
    for (int b = 0; b < 7; b++) begin
      strobe_f(); gap();
      strobe_r(1'b0); gap();
    end
    check("rd_miso_held", if0.miso_buff, 1);
    strobe_f();
    check("rd_miso_after_word", if0.miso_buff, BURST);
    gap();
    check("rd_sr_count", sr0 - s_sr, 1 + BURST);
    check("rd_no_dm", dm0 - s_dm, 0);
    cs = 1'b1;
    gap();
    check("rd_no_frame_err", fe0 - s_fe, 0);
    check("rd_end_outs", o0, 0);

    // cs rises together with the completing write rise
    s_dm = dm0; s_fe = fe0;
    cs = 1'b0;
    tick();
    send_bits(7'h33, 7);
    strobe_r(1'b0);
    gap();
    send_bits(7'h11, 7);
    cs = 1'b1;
    strobe_r(1'b1);
    check("abort_no_dm", if0.dm_we, 0);
    check("abort_frame_err", if0.frame_err, 1);
    tick();
    check("abort_err_single", if0.frame_err, 0);
    gap();
    check("abort_dm_count", dm0 - s_dm, 0);
    check("abort_err_count", fe0 - s_fe, 1);

    // Coincident rise+fall strobes in READ: the falls must not count
    s_fe = fe0;
    cs = 1'b0;
    tick();
    send_bits(7'h01, 7);
    strobe_r(1'b1);
    gap();
    for (int b = 0; b < 8; b++) begin
      sclk_rise = 1'b1;
      sclk_fall = 1'b1;
      tick();
      sclk_rise = 1'b0;
      sclk_fall = 1'b0;
      gap();
    end
    check("both_strobes_miso", if0.miso_buff, 1);
    cs = 1'b1;
    gap();
    check("both_strobes_no_err", fe0 - s_fe, 0);

    // ADDR_W=4, DATA_W=12 instance: write aborted after 6 data bits
    s_dm1 = dm1; s_fe1 = fe1;
    cs = 1'b0;
    tick();
    send_bits(4'hA, 4);
    strobe_r(1'b0);
    gap();
    send_bits(6'h2D, 6);
    cs = 1'b1;
    tick();
    check("u1_frame_err", if1.frame_err, 1);
    tick();
    check("u1_frame_err_single", if1.frame_err, 0);
    check("u1_idle_outs", o1, 0);
    check("u1_no_dm", dm1 - s_dm1, 0);
    check("u1_err_count", fe1 - s_fe1, 1);
    cs = 1'b0;
    tick();
    check("u1_idle_reentry", if1.addr_we, 1);
    cs = 1'b1;
    gap();

`ifdef SPI_SLAVE_BURST_EN
    // Burst read of 3 words from 0x7E; cs rises on the last fall
    s_sr = sr0; s_inc = inc0; s_fe = fe0;
    cs = 1'b0;
    tick();
    send_bits(7'h7E, 7);
    strobe_r(1'b1);
    gap();
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 8; b++) begin
        if (w == 2 && b == 7) cs = 1'b1;
        strobe_f();
        if (b == 7 && w < 2) begin
          check("burst_addr_inc", if0.addr_inc, 1);
          tick();
          check("burst_sr_reload", if0.sr_we, 1);
          tick();
        end else begin
          gap();
        end
      end
    end
    gap();
    check("burst_inc_count", inc0 - s_inc, 2);
    check("burst_sr_count", sr0 - s_sr, 3);
    check("burst_no_frame_err", fe0 - s_fe, 0);

    // Burst write of 2 words
    s_dm = dm0; s_inc = inc0; s_fe = fe0;
    cs = 1'b0;
    tick();
    send_bits(7'h7F, 7);
    strobe_r(1'b0);
    gap();
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    cs = 1'b1;
    gap();
    check("burst_wr_dm_count", dm0 - s_dm, 2);
    check("burst_wr_inc_count", inc0 - s_inc, 2);
    check("burst_wr_no_err", fe0 - s_fe, 0);
`else
    check("no_addr_inc_ever", inc0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Parametrised SPI slave transaction controller, successor to the fixed 7-bit-address / 8-bit-data slave FSM. It runs on the system clock and consumes single-cycle SCLK edge strobes from the input conditioner. It drives the address latch, shift-register parallel load, data-memory write and MISO tri-state enable. It adds generic address/data widths, framing-error detection, correct partial-frame abort, and an optional burst (auto-increment) mode.

## Interface
Parameters:
- ADDR_W, 7, address bits per frame (1..15)
- DATA_W, 8, data bits per word (1..16)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- sclk_rise  in  1  one-clk pulse per conditioned SCLK rising edge (MOSI sample point)
- sclk_fall  in  1  one-clk pulse per conditioned SCLK falling edge (MISO shift point)
- cs  in  1  conditioned chip select, high = deselected
- mosi  in  1  conditioned MOSI level; read by this block only for the R/W bit
- miso_buff  out  1  MISO output-buffer enable
- addr_we  out  1  address latch write enable
- sr_we  out  1  shift-register parallel-load enable (one-clk pulse)
- dm_we  out  1  data-memory write enable (one-clk pulse)
- addr_inc  out  1  address latch increment pulse (burst only)
- frame_err  out  1  one-clk pulse when cs rises mid-frame

## Operation
- Frame, MSB first: ADDR_W address bits, 1 R/W bit (1 = read), then DATA_W data bits per word.
- Bit counter width is $clog2(max(ADDR_W, DATA_W)+1). It is cleared on every state entry.
- States:
  - IDLE: all outputs 0. cs==0 moves to ADDR, with addr_we=1 from the next clk.
  - ADDR: addr_we=1. The counter counts sclk_rise. On the ADDR_W-th rise: addr_we=0 next clk, go to RW.
  - RW: on sclk_rise, sample mosi.
    - mosi=1: go to READ, sr_we=1 and miso_buff=1 next clk.
    - mosi=0: go to WRITE.
  - READ: miso_buff=1. sr_we is high only in the first clk of READ. The counter counts sclk_fall. On the DATA_W-th fall, go to DONE (burst: see Configuration).
  - WRITE: the counter counts sclk_rise. On the DATA_W-th rise, dm_we=1 for exactly the next clk, then go to DONE.
  - DONE: outputs 0. Extra SCLK edges are ignored. cs==1 returns to IDLE.
- cs==1 in any state except IDLE/DONE:
  - Next clk: IDLE with all enables 0.
  - frame_err=1 for that one clk if the state is ADDR, RW, or has a nonzero counter. A write with a partial word never produces dm_we.
- cs==1 in the same clk as a completing sclk_rise in WRITE: the abort wins, with no dm_we.
- sclk_rise and sclk_fall never assert together; if both are high, sclk_fall is ignored.

## Timing
- Reset: state IDLE, counter 0, miso_buff/addr_we/sr_we/dm_we/addr_inc/frame_err = 0. Reset mid-frame behaves identically, with no frame_err.
- All outputs are registered; each reacts one clk after the causing strobe.
- addr_we falls 1 clk after the ADDR_W-th sclk_rise.
- sr_we/miso_buff rise 1 clk after the R/W sclk_rise. The upstream SCLK half-period must be ≥ 3 clk for the load to precede the first sclk_fall.
- dm_we is 1 clk after the final data sclk_rise.

## Configuration
- SPI_SLAVE_BURST_EN defined:
  - READ: after the DATA_W-th sclk_fall, with cs still 0, pulse addr_inc, then pulse sr_we the following clk. Stay in READ with the counter cleared.
  - WRITE: after the dm_we clk, pulse addr_inc the next clk. Stay in WRITE with the counter cleared.
  - Address wraps modulo 2^ADDR_W; the address latch handles the wrap.
- Undefined: addr_inc is tied 0, and the controller goes to DONE after one word.

## Test plan
- Reset while in WRITE with counter=3 -> all outputs 0 immediately, state IDLE, no frame_err.
- Defaults, write frame addr 0x15, R/W=0, data 0xA5 -> addr_we high over 7 rises, one dm_we pulse 1 clk after the 16th rise, no sr_we.
- Defaults, read frame addr 0x7F -> sr_we single pulse 1 clk after the 8th rise, miso_buff high over 8 falls, then 0 in DONE.
- ADDR_W=4, DATA_W=12, write with cs raised after 6 data bits -> frame_err one pulse, no dm_we, state IDLE.
- SPI_SLAVE_BURST_EN, read 3 words from addr 0x7E -> addr_inc pulses twice, sr_we pulses 3 times (each 1 clk after addr_inc for words 2–3), frame ends cleanly on cs rise with no frame_err.
- Extra 5 SCLK edges after a single-word write (burst off) -> no further dm_we/addr_inc, DONE held until cs=1.
